// File: rtl/axi_lite_slave_mem.sv
// AXI4-Lite slave word memory: independent write (AW/W/B) and read (AR/R) engines over one word array.
// Define AXIL_SLV_RANGE_CHECK_EN to answer SLVERR outside [BASE, BASE+4*DEPTH); otherwise addresses alias.
module axi_lite_slave_mem #(
   parameter int                            C_S_AXI_ADDR_WIDTH = 32,
   parameter int                            C_S_AXI_DATA_WIDTH = 32,
   parameter logic [C_S_AXI_ADDR_WIDTH-1:0] C_S_BASE_ADDR      = 32'h40000000,
   parameter int                            C_S_MEM_DEPTH      = 1024
) (
   input  logic                            s00_axi_aclk,
   input  logic                            s00_axi_areset,
   input  logic [C_S_AXI_ADDR_WIDTH-1:0]   s00_axi_awaddr,
   input  logic [2:0]                      s00_axi_awprot,
   input  logic                            s00_axi_awvalid,
   output logic                            s00_axi_awready,
   input  logic [C_S_AXI_DATA_WIDTH-1:0]   s00_axi_wdata,
   input  logic [C_S_AXI_DATA_WIDTH/8-1:0] s00_axi_wstrb,
   input  logic                            s00_axi_wvalid,
   output logic                            s00_axi_wready,
   output logic [1:0]                      s00_axi_bresp,
   output logic                            s00_axi_bvalid,
   input  logic                            s00_axi_bready,
   input  logic [C_S_AXI_ADDR_WIDTH-1:0]   s00_axi_araddr,
   input  logic [2:0]                      s00_axi_arprot,
   input  logic                            s00_axi_arvalid,
   output logic                            s00_axi_arready,
   output logic [C_S_AXI_DATA_WIDTH-1:0]   s00_axi_rdata,
   output logic [1:0]                      s00_axi_rresp,
   output logic                            s00_axi_rvalid,
   input  logic                            s00_axi_rready,
   output logic [31:0]                     wr_count,
   output logic [31:0]                     rd_count
);

   localparam int AW   = C_S_AXI_ADDR_WIDTH;
   localparam int DW   = C_S_AXI_DATA_WIDTH;
   localparam int IDXW = $clog2(C_S_MEM_DEPTH);

   typedef enum logic [1:0] {W_IDLE, W_COMMIT, W_RESP} w_state_t;
   typedef enum logic       {R_IDLE, R_DATA}           r_state_t;

   w_state_t w_state, w_state_next;
   r_state_t r_state, r_state_next;

   logic [DW-1:0]   mem [0:C_S_MEM_DEPTH-1];
   logic            aw_held, w_held;
   logic [AW-1:0]   aw_addr_q;
   logic [DW-1:0]   w_data_q;
   logic [AW-1:0]   wr_offset, rd_offset;
   logic [IDXW-1:0] wr_idx, rd_idx;
   logic            wr_in_range, rd_in_range;
   logic            aw_fire, w_fire, ar_fire;
   logic            unused_ok;

   assign wr_offset = aw_addr_q - C_S_BASE_ADDR;
   assign rd_offset = s00_axi_araddr - C_S_BASE_ADDR;
   assign wr_idx    = wr_offset[IDXW+1:2];
   assign rd_idx    = rd_offset[IDXW+1:2];

`ifdef AXIL_SLV_RANGE_CHECK_EN
   assign wr_in_range = (wr_offset[AW-1:IDXW+2] == '0);
   assign rd_in_range = (rd_offset[AW-1:IDXW+2] == '0);
`else
   assign wr_in_range = 1'b1;
   assign rd_in_range = 1'b1;
`endif

   assign unused_ok = ^{s00_axi_awprot, s00_axi_arprot, s00_axi_wstrb,
                        wr_offset[1:0], rd_offset[1:0],
                        wr_offset[AW-1:IDXW+2], rd_offset[AW-1:IDXW+2]};

   // Readies are gated by reset so nothing is accepted while reset is asserted
   assign s00_axi_awready = !s00_axi_areset && !aw_held && (w_state != W_RESP);
   assign s00_axi_wready  = !s00_axi_areset && !w_held  && (w_state != W_RESP);
   assign s00_axi_bvalid  = (w_state == W_RESP);
   assign s00_axi_arready = !s00_axi_areset && (r_state == R_IDLE);
   assign s00_axi_rvalid  = (r_state == R_DATA);

   assign aw_fire = s00_axi_awvalid && s00_axi_awready;
   assign w_fire  = s00_axi_wvalid  && s00_axi_wready;
   assign ar_fire = s00_axi_arvalid && s00_axi_arready;

   always_ff @(posedge s00_axi_aclk or posedge s00_axi_areset) begin
      if (s00_axi_areset) begin
         w_state <= W_IDLE;
         r_state <= R_IDLE;
      end else begin
         w_state <= w_state_next;
         r_state <= r_state_next;
      end
   end

   always_comb begin
      w_state_next = w_state;
      case (w_state)
         W_IDLE:   if (aw_held && w_held) w_state_next = W_COMMIT;
         W_COMMIT: w_state_next = W_RESP;
         W_RESP:   if (s00_axi_bready) w_state_next = W_IDLE;
         default:  w_state_next = W_IDLE;
      endcase
   end

   always_comb begin
      r_state_next = r_state;
      case (r_state)
         R_IDLE:  if (ar_fire) r_state_next = R_DATA;
         R_DATA:  if (s00_axi_rready) r_state_next = R_IDLE;
         default: r_state_next = R_IDLE;
      endcase
   end

   // AW and W park independently; the commit cycle drains both holding registers at once
   always_ff @(posedge s00_axi_aclk or posedge s00_axi_areset) begin
      if (s00_axi_areset) begin
         aw_held       <= 1'b0;
         w_held        <= 1'b0;
         aw_addr_q     <= '0;
         w_data_q      <= '0;
         s00_axi_bresp <= 2'b00;
         wr_count      <= 32'd0;
      end else begin
         if (aw_fire) begin
            aw_held   <= 1'b1;
            aw_addr_q <= s00_axi_awaddr;
         end
         if (w_fire) begin
            w_held   <= 1'b1;
            w_data_q <= s00_axi_wdata;
         end
         if (w_state == W_COMMIT) begin
            aw_held       <= 1'b0;
            w_held        <= 1'b0;
            s00_axi_bresp <= wr_in_range ? 2'b00 : 2'b10;
            if (wr_in_range) wr_count <= wr_count + 32'd1;
         end
      end
   end

   // Array is deliberately not reset; reset holds the write FSM idle so no write can fire
   always_ff @(posedge s00_axi_aclk) begin
      if ((w_state == W_COMMIT) && wr_in_range) mem[wr_idx] <= w_data_q;
   end

   // Read data is sampled with nonblocking semantics, so a same-edge commit yields the old word
   always_ff @(posedge s00_axi_aclk or posedge s00_axi_areset) begin
      if (s00_axi_areset) begin
         s00_axi_rdata <= '0;
         s00_axi_rresp <= 2'b00;
         rd_count      <= 32'd0;
      end else begin
         if (ar_fire) begin
            s00_axi_rdata <= rd_in_range ? mem[rd_idx] : '0;
            s00_axi_rresp <= rd_in_range ? 2'b00 : 2'b10;
         end
         if ((r_state == R_DATA) && s00_axi_rready) rd_count <= rd_count + 32'd1;
      end
   end

endmodule

// File: tb/tb_axi_lite_slave_mem.sv
// Bench for axi_lite_slave_mem: directed AXI-Lite scenarios plus random traffic,
// checked every cycle against a transaction-level memory model.
module tb_axi_lite_slave_mem;

   localparam logic [31:0] BASE  = 32'h40000000;
   localparam int          DEPTH = 1024;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] awaddr, wdata, araddr, rdata, wr_count, rd_count;
   logic [2:0]  awprot, arprot;
   logic [3:0]  wstrb;
   logic        awvalid, awready, wvalid, wready, bvalid, bready;
   logic        arvalid, arready, rvalid, rready;
   logic [1:0]  bresp, rresp;

   int tests_run    = 0;
   int tests_failed = 0;

   always #5 clk = ~clk;

   axi_lite_slave_mem dut (
      .s00_axi_aclk(clk),       .s00_axi_areset(rst),
      .s00_axi_awaddr(awaddr),  .s00_axi_awprot(awprot),
      .s00_axi_awvalid(awvalid), .s00_axi_awready(awready),
      .s00_axi_wdata(wdata),    .s00_axi_wstrb(wstrb),
      .s00_axi_wvalid(wvalid),  .s00_axi_wready(wready),
      .s00_axi_bresp(bresp),    .s00_axi_bvalid(bvalid),  .s00_axi_bready(bready),
      .s00_axi_araddr(araddr),  .s00_axi_arprot(arprot),
      .s00_axi_arvalid(arvalid), .s00_axi_arready(arready),
      .s00_axi_rdata(rdata),    .s00_axi_rresp(rresp),
      .s00_axi_rvalid(rvalid),  .s00_axi_rready(rready),
      .wr_count(wr_count),      .rd_count(rd_count)
   );

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      tests_run++;
      if (actual !== expected) begin
         tests_failed++;
         $display("[TB] FAIL %s: got %h, expected %h at %0t", name, actual, expected, $time);
      end
   endtask

   task automatic noteTimeout(input string name);
      tests_run++;
      tests_failed++;
      $display("[TB] FAIL %s: timed out at %0t", name, $time);
   endtask

   function automatic bit addrInRange(input logic [31:0] a);
`ifdef AXIL_SLV_RANGE_CHECK_EN
      return (a - BASE) < 32'(4 * DEPTH);
`else
      return 1'b1;
`endif
   endfunction

   function automatic int addrIndex(input logic [31:0] a);
      logic [31:0] off;
      off = a - BASE;
      return int'((off / 4) % DEPTH);
   endfunction

   // Transaction-level reference: a word array plus outstanding-transaction bookkeeping
   logic [31:0] model_mem [0:DEPTH-1];
   bit          model_known [0:DEPTH-1];
   bit          aw_m, w_m, b_pend, r_out;
   int          pair_age;
   logic [31:0] aw_addr_m, w_data_m, model_wr, model_rd, exp_rdata;
   logic [1:0]  exp_bresp, exp_rresp;
   bit          exp_rknown;
   bit          hs_aw, hs_w, hs_b, hs_ar, hs_r, hs_ar_known;
   logic [31:0] hs_aw_addr, hs_w_data, hs_ar_data;
   logic [1:0]  hs_ar_resp;

   always @(negedge clk) begin
      if (rst) begin
         checkOutput("reset_awready", awready, 0);
         checkOutput("reset_wready", wready, 0);
         checkOutput("reset_arready", arready, 0);
         checkOutput("reset_bvalid", bvalid, 0);
         checkOutput("reset_rvalid", rvalid, 0);
         checkOutput("reset_rdata", rdata, 0);
         checkOutput("reset_wr_count", wr_count, 0);
         checkOutput("reset_rd_count", rd_count, 0);
         aw_m = 0; w_m = 0; b_pend = 0; r_out = 0; pair_age = 0;
         model_wr = 0; model_rd = 0;
         hs_aw = 0; hs_w = 0; hs_b = 0; hs_ar = 0; hs_r = 0;
      end else begin
         if (hs_aw) begin aw_m = 1; aw_addr_m = hs_aw_addr; end
         if (hs_w)  begin w_m = 1;  w_data_m = hs_w_data; end
         if (hs_b)  b_pend = 0;
         if (hs_ar) begin
            r_out = 1; exp_rdata = hs_ar_data; exp_rresp = hs_ar_resp; exp_rknown = hs_ar_known;
         end
         if (hs_r) begin r_out = 0; model_rd++; end
         // A complete AW+W pair becomes visible (memory, count, bvalid) two edges after it completes
         if (aw_m && w_m) begin
            pair_age++;
            if (pair_age == 3) begin
               if (addrInRange(aw_addr_m)) begin
                  model_mem[addrIndex(aw_addr_m)]   = w_data_m;
                  model_known[addrIndex(aw_addr_m)] = 1;
                  model_wr++;
                  exp_bresp = 2'b00;
               end else begin
                  exp_bresp = 2'b10;
               end
               aw_m = 0; w_m = 0; pair_age = 0; b_pend = 1;
            end
         end
         checkOutput("awready", awready, !aw_m && !b_pend);
         checkOutput("wready", wready, !w_m && !b_pend);
         checkOutput("bvalid", bvalid, b_pend);
         if (b_pend) checkOutput("bresp", bresp, exp_bresp);
         checkOutput("arready", arready, !r_out);
         checkOutput("rvalid", rvalid, r_out);
         if (r_out) begin
            checkOutput("rresp", rresp, exp_rresp);
            if (exp_rknown) checkOutput("rdata", rdata, exp_rdata);
         end
         checkOutput("wr_count", wr_count, model_wr);
         checkOutput("rd_count", rd_count, model_rd);
         hs_aw = awvalid && !aw_m && !b_pend;  hs_aw_addr = awaddr;
         hs_w  = wvalid && !w_m && !b_pend;    hs_w_data  = wdata;
         hs_b  = b_pend && bready;
         hs_r  = r_out && rready;
         hs_ar = arvalid && !r_out;
         if (addrInRange(araddr)) begin
            hs_ar_data  = model_mem[addrIndex(araddr)];
            hs_ar_known = model_known[addrIndex(araddr)];
            hs_ar_resp  = 2'b00;
         end else begin
            hs_ar_data = 32'h0; hs_ar_known = 1; hs_ar_resp = 2'b10;
         end
      end
   end

   task automatic writeWord(input logic [31:0] addr, input logic [31:0] data,
                            input int aw_dly, input int w_dly, input int b_dly,
                            output logic [1:0] resp);
      bit aw_done, w_done;
      int cyc;
      aw_done = 0; w_done = 0; cyc = 0;
      awaddr = addr; wdata = data;
      while (!(aw_done && w_done) && cyc < 50) begin
         awvalid = !aw_done && (cyc >= aw_dly);
         wvalid  = !w_done && (cyc >= w_dly);
         @(negedge clk);
         if (awvalid && awready) aw_done = 1;
         if (wvalid && wready)   w_done = 1;
         @(posedge clk); #1;
         cyc++;
      end
      awvalid = 0; wvalid = 0;
      if (!(aw_done && w_done)) noteTimeout("aw_w_handshake");
      cyc = 0;
      while (!bvalid && cyc < 20) begin @(posedge clk); #1; cyc++; end
      if (!bvalid) noteTimeout("bvalid_wait");
      repeat (b_dly) begin @(posedge clk); #1; end
      resp = bresp;
      bready = 1;
      @(posedge clk); #1;
      bready = 0;
   endtask

   task automatic readWord(input logic [31:0] addr, input int ar_dly, input int r_dly,
                           output logic [31:0] data, output logic [1:0] resp);
      bit done;
      int cyc;
      repeat (ar_dly) begin @(posedge clk); #1; end
      araddr = addr; arvalid = 1; done = 0; cyc = 0;
      while (!done && cyc < 50) begin
         @(negedge clk);
         if (arready) done = 1;
         @(posedge clk); #1;
         cyc++;
      end
      arvalid = 0;
      if (!done) noteTimeout("ar_handshake");
      cyc = 0;
      while (!rvalid && cyc < 20) begin @(posedge clk); #1; cyc++; end
      if (!rvalid) noteTimeout("rvalid_wait");
      repeat (r_dly) begin @(posedge clk); #1; end
      data = rdata; resp = rresp;
      rready = 1;
      @(posedge clk); #1;
      rready = 0;
   endtask

   // Random phase: concurrent write and read to a small window, occasionally past the top of memory
   task automatic applyStimulus(input int n);
      logic [31:0] wa, ra, d;
      logic [1:0]  br, rr;
      for (int k = 0; k < n; k++) begin
         wa = BASE + 32'(4 * $urandom_range(0, 63));
         ra = BASE + 32'(4 * $urandom_range(0, 63));
         if ($urandom_range(0, 7) == 0) wa = wa + 32'h1000;
         if ($urandom_range(0, 7) == 0) ra = ra + 32'h1000;
         fork
            writeWord(wa, $urandom, $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3), br);
            readWord(ra, $urandom_range(0, 3), $urandom_range(0, 3), d, rr);
         join
      end
   endtask

   initial begin
      #2_000_000;
      $display("[TB] FAIL watchdog: simulation did not finish");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      logic [31:0] d;
      logic [1:0]  r;
      rst = 1; awaddr = 0; awprot = 0; awvalid = 0; wdata = 0; wstrb = 4'hF; wvalid = 0;
      bready = 0; araddr = 0; arprot = 0; arvalid = 0; rready = 0;
      for (int i = 0; i < DEPTH; i++) model_known[i] = 0;
      repeat (3) @(posedge clk);
      #1 rst = 0;

      for (int i = 0; i < DEPTH; i++) writeWord(BASE + 32'(4 * i), 32'hAA000000 + 32'(i), 0, 0, 0, r);
      for (int i = 0; i < DEPTH; i++) begin
         readWord(BASE + 32'(4 * i), 0, 0, d, r);
         checkOutput("fill_readback", d, 32'hAA000000 + 32'(i));
         checkOutput("fill_rresp", r, 2'b00);
      end
      @(negedge clk);
      checkOutput("fill_wr_count", wr_count, 32'd1024);
      checkOutput("fill_rd_count", rd_count, 32'd1024);
      @(posedge clk); #1;

      writeWord(BASE + 32'd80, 32'h5555AAAA, 0, 3, 0, r);
      writeWord(BASE + 32'd84, 32'hAAAA5555, 3, 0, 0, r);
      readWord(BASE + 32'd80, 0, 0, d, r);
      checkOutput("aw_first_data", d, 32'h5555AAAA);
      readWord(BASE + 32'd84, 0, 0, d, r);
      checkOutput("w_first_data", d, 32'hAAAA5555);

      writeWord(BASE + 32'd88, 32'hCAFEF00D, 0, 0, 5, r);
      checkOutput("b_hold_resp", r, 2'b00);
      readWord(BASE + 32'd88, 0, 4, d, r);
      checkOutput("r_hold_data", d, 32'hCAFEF00D);

      fork
         writeWord(BASE + 32'd28, 32'h12345678, 0, 0, 0, r);
         readWord(BASE + 32'd28, 2, 0, d, r);
      join
      checkOutput("read_first_old", d, 32'hAA000007);
      readWord(BASE + 32'd28, 0, 0, d, r);
      checkOutput("read_after_write", d, 32'h12345678);

      wdata = 32'hBAD0BAD0; wvalid = 1;
      @(negedge clk);
      checkOutput("lone_w_ready", wready, 1);
      @(posedge clk); #1;
      wvalid = 0;
      repeat (2) @(posedge clk);
      #1 rst = 1;
      repeat (2) @(posedge clk);
      #1 rst = 0;
      @(negedge clk);
      checkOutput("post_reset_wready", wready, 1);
      checkOutput("post_reset_bvalid", bvalid, 0);
      checkOutput("post_reset_wr_count", wr_count, 0);
      repeat (4) @(posedge clk);
      #1;

      writeWord(BASE + 32'h1000, 32'hDEADBEEF, 0, 0, 0, r);
      readWord(BASE, 0, 0, d, r);
`ifdef AXIL_SLV_RANGE_CHECK_EN
      checkOutput("range_bresp", 32'(r == 2'b00 ? 2'b00 : 2'b00) | 32'(bresp), 2'b10);
      checkOutput("range_mem0", d, 32'hAA000000);
      checkOutput("range_wr_count", wr_count, 0);
`else
      checkOutput("alias_mem0", d, 32'hDEADBEEF);
      checkOutput("alias_wr_count", wr_count, 1);
`endif

      applyStimulus(300);
      repeat (5) @(posedge clk);
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
